div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing the divider (2..4).
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding divider operations (power of 2).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port s_aclk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port s_areset  in  1  synchronous active-high reset.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester divide request.
REQ-007 SHALL have port req_ready  out  N_REQ  per-requester request accepted.
REQ-008 SHALL have port req_dividend  in  32*N_REQ  packed dividends; requester k at bits [32k+31:32k].
REQ-009 SHALL have port req_divisor  in  32*N_REQ  packed divisors, same packing.
REQ-010 SHALL have port rsp_valid  out  N_REQ  one-hot quotient valid for the owning requester.
REQ-011 SHALL have port rsp_ready  in  N_REQ  per-requester response accept.
REQ-012 SHALL have port rsp_data  out  32  quotient for the requester flagged in rsp_valid.
REQ-013 SHALL have ports s_axis_dividend_tvalid out 1, s_axis_dividend_tdata out 32, m_axis_dividend_tready in 1  divider dividend channel.
REQ-014 SHALL have ports s_axis_divisor_tvalid out 1, s_axis_divisor_tdata out 32, m_axis_divisor_tready in 1  divider divisor channel.
REQ-015 SHALL have ports m_axis_dout_tvalid in 1, m_axis_dout_tdata in 32, m_axis_dout_tready out 1  divider result channel.
REQ-016 SHALL have port outstanding  out  $clog2(MAX_OUT)+1  count of issued, unreturned operations.
REQ-017 SHALL have port zero_div_cnt  out  16  saturating count of issued requests with divisor 0.
REQ-018 SHALL have port unexp_rsp  out  1  sticky flag: result beat received with no outstanding operation.

Function
REQ-019 SHALL implement FSM states IDLE and ISSUE.
REQ-020 In IDLE with outstanding < MAX_OUT and any req_valid set, SHALL select a winner round-robin, highest priority at last_grant+1 mod N_REQ.
REQ-021 SHALL assert req_ready combinationally for the winner only, in IDLE only, never for more than one requester per cycle.
REQ-022 On the winner's req_valid&req_ready edge, SHALL capture dividend, divisor and requester index, update last_grant, and enter ISSUE.
REQ-023 On entry to ISSUE, SHALL assert both s_axis_*_tvalid with the captured data; first tvalid is one cycle after acceptance.
REQ-024 SHALL deassert each channel's tvalid independently, on the cycle after its own tready is sampled high; tdata SHALL be stable while tvalid is high.
REQ-025 When both channels have completed their handshake, SHALL push the requester index into an in-order tag FIFO of depth MAX_OUT and return to IDLE; minimum issue interval is 2 cycles.
REQ-026 At the push in REQ-025, if the divisor is 0, SHALL increment zero_div_cnt, saturating at 0xFFFF; the request is still forwarded unchanged.
REQ-027 SHALL drive m_axis_dout_tready = 1 exactly when the response holding register is empty.
REQ-028 On a dout beat with tag FIFO non-empty, SHALL pop the tag, load rsp_data, and assert rsp_valid[tag] on the next cycle.
REQ-029 On a dout beat with tag FIFO empty, SHALL discard the data and set unexp_rsp until reset.
REQ-030 SHALL hold rsp_valid and rsp_data until rsp_ready of the flagged requester is high, then clear the holding register.
REQ-031 SHALL leave outstanding unchanged on a simultaneous push and pop, and never exceed MAX_OUT.
REQ-032 SHALL block new grants while outstanding == MAX_OUT; ISSUE in progress SHALL complete regardless.
REQ-033 SHALL deliver results to requesters in issue order, with no reordering.

Reset
REQ-034 While s_areset is high, SHALL set state IDLE, last_grant N_REQ-1, all tvalid/req_ready/rsp_valid/m_axis_dout_tready 0, tdata/rsp_data 0, tag FIFO empty, outstanding 0, zero_div_cnt 0, unexp_rsp 0.
REQ-035 Reset mid-operation SHALL drop all in-flight tags; late divider results after reset SHALL set unexp_rsp.

Verification
REQ-036 Single request: req0 = 100/7, divider trays ready, returns 14 -> tvalids 1 cycle after accept, rsp_valid=01, rsp_data=14.
REQ-037 Both requesters continuously valid after reset -> grants alternate req0, req1, req0...; results route to matching rsp_valid bit in order.
REQ-038 Divisor tready delayed 3 cycles, dividend immediate -> dividend tvalid drops after 1 cycle, divisor tvalid held 4 cycles, single tag push.
REQ-039 Divider withholds results, 5 requests offered -> 4 issued, outstanding=4, req_ready stays 0 until first result returns.
REQ-040 Divisor 0 issued twice, then unsolicited dout beat after reset -> zero_div_cnt=2 before reset; unexp_rsp=1, no rsp_valid.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one AXI-Stream divider among N_REQ requesters with in-order result routing
// Ports:
//   s_aclk, s_areset            clock, synchronous active-high reset
//   req_valid/ready/dividend/divisor   per-requester request side (32-bit lanes packed by index)
//   rsp_valid/ready, rsp_data   one-hot response to the requester that owns the returned quotient
//   s_axis_dividend_*/s_axis_divisor_*  operand channels to the divider
//   m_axis_dout_*               quotient channel from the divider
//   outstanding, zero_div_cnt, unexp_rsp   status: in-flight ops, divide-by-zero count, sticky unexpected-result flag
module div_arbiter #(
    parameter int N_REQ   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                      s_aclk,
    input  logic                      s_areset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [32*N_REQ-1:0]       req_dividend,
    input  logic [32*N_REQ-1:0]       req_divisor,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [31:0]               rsp_data,
    output logic                      s_axis_dividend_tvalid,
    output logic [31:0]               s_axis_dividend_tdata,
    input  logic                      m_axis_dividend_tready,
    output logic                      s_axis_divisor_tvalid,
    output logic [31:0]               s_axis_divisor_tdata,
    input  logic                      m_axis_divisor_tready,
    input  logic                      m_axis_dout_tvalid,
    input  logic [31:0]               m_axis_dout_tdata,
    output logic                      m_axis_dout_tready,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic [15:0]               zero_div_cnt,
    output logic                      unexp_rsp
);
    localparam int TW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int AW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   last_grant, win, cap_tag, hold_tag;
    logic [N_REQ-1:0] rot;
    logic            grant, accept, dvd_done, dvs_done, push, pop, dout_fire, hold_valid;
    logic [TW-1:0]   tag_mem [MAX_OUT];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    // rot[j] is the request sitting j+1 places after last_grant; the lowest set j wins
    always_comb begin
        rot = N_REQ'({req_valid, req_valid} >> (32'(last_grant) + 32'd1));
        win = last_grant;
        for (int j = N_REQ - 1; j >= 0; j--)
            if (rot[j]) win = TW'((32'(last_grant) + 32'd1 + 32'(j)) % 32'(N_REQ));
        grant = state == IDLE && !s_areset && 32'(outstanding) < MAX_OUT && |req_valid;
        req_ready = grant ? N_REQ'(1) << win : '0;
        accept = |(req_valid & req_ready);
        // a channel is done once its tvalid has dropped or its handshake happens this cycle
        dvd_done = !s_axis_dividend_tvalid || m_axis_dividend_tready;
        dvs_done = !s_axis_divisor_tvalid || m_axis_divisor_tready;
        push = state == ISSUE && dvd_done && dvs_done;
        state_nxt = accept ? ISSUE : push ? IDLE : state;
        m_axis_dout_tready = !hold_valid && !s_areset;
        dout_fire = m_axis_dout_tvalid && m_axis_dout_tready;
        pop = dout_fire && outstanding != '0;
        rsp_valid = hold_valid ? N_REQ'(1) << hold_tag : '0;
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            state                  <= IDLE;
            last_grant             <= TW'(N_REQ - 1);
            cap_tag                <= '0;
            s_axis_dividend_tvalid <= 1'b0;
            s_axis_divisor_tvalid  <= 1'b0;
            s_axis_dividend_tdata  <= '0;
            s_axis_divisor_tdata   <= '0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            outstanding            <= '0;
            zero_div_cnt           <= '0;
            unexp_rsp              <= 1'b0;
            hold_valid             <= 1'b0;
            hold_tag               <= '0;
            rsp_data               <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant             <= win;
                cap_tag                <= win;
                s_axis_dividend_tdata  <= req_dividend[32*win +: 32];
                s_axis_divisor_tdata   <= req_divisor[32*win +: 32];
                s_axis_dividend_tvalid <= 1'b1;
                s_axis_divisor_tvalid  <= 1'b1;
            end else begin
                if (m_axis_dividend_tready) s_axis_dividend_tvalid <= 1'b0;
                if (m_axis_divisor_tready) s_axis_divisor_tvalid <= 1'b0;
            end
            if (push) begin
                tag_mem[wr_ptr] <= cap_tag;
                wr_ptr          <= wr_ptr + 1'b1;
                if (s_axis_divisor_tdata == '0 && zero_div_cnt != 16'hFFFF) zero_div_cnt <= zero_div_cnt + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + OW'(push) - OW'(pop);
            if (dout_fire) begin
                if (pop) begin
                    hold_valid <= 1'b1;
                    hold_tag   <= tag_mem[rd_ptr];
                    rsp_data   <= m_axis_dout_tdata;
                end else begin
                    unexp_rsp <= 1'b1;
                end
            end else if (hold_valid && rsp_ready[hold_tag]) begin
                hold_valid <= 1'b0;
                rsp_data   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed table-driven bench for div_arbiter with hand-written multi-cycle sequences
module tb_div_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_dividend, req_divisor;
    logic [31:0] rsp_data;
    logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready;
    logic [31:0] dvd_tdata, dvs_tdata;
    logic        dout_tvalid, dout_tready;
    logic [31:0] dout_tdata;
    logic [2:0]  outstanding;
    logic [15:0] zero_div_cnt;
    logic        unexp_rsp;
    int          n_vec = 0, n_bad = 0, acc;

    always #5 clk = ~clk;

    div_arbiter dut (
        .s_aclk(clk), .s_areset(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .s_axis_dividend_tvalid(dvd_tvalid), .s_axis_dividend_tdata(dvd_tdata), .m_axis_dividend_tready(dvd_tready),
        .s_axis_divisor_tvalid(dvs_tvalid), .s_axis_divisor_tdata(dvs_tdata), .m_axis_divisor_tready(dvs_tready),
        .m_axis_dout_tvalid(dout_tvalid), .m_axis_dout_tdata(dout_tdata), .m_axis_dout_tready(dout_tready),
        .outstanding(outstanding), .zero_div_cnt(zero_div_cnt), .unexp_rsp(unexp_rsp)
    );

    typedef struct packed {
        logic [1:0]  rv;
        logic        dv;
        logic [31:0] dd;
        logic [1:0]  rspr;
        logic [1:0]  rr;
        logic [1:0]  tv;
        logic [31:0] dvdd;
        logic [31:0] dvsd;
        logic [1:0]  rspv;
        logic [31:0] rd;
        logic [2:0]  outs;
        logic        dtr;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic [1:0] rv, logic dv, logic [31:0] dd, logic [1:0] rspr,
                                logic [1:0] rr, logic [1:0] tv, logic [31:0] dvdd, logic [31:0] dvsd,
                                logic [1:0] rspv, logic [31:0] rd, logic [2:0] outs, logic dtr);
        mk = {rv, dv, dd, rspr, rr, tv, dvdd, dvsd, rspv, rd, outs, dtr};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        //             rv    dv    dd      rspr   rr     tv     dvdd     dvsd   rspv   rd      out   dtr
        tbl[0]  = mk(2'b00, 1'b0, 32'd0,  2'b00, 2'b00, 2'b00, 32'd0,   32'd0, 2'b00, 32'd0,  3'd0, 1'b1);
        tbl[1]  = mk(2'b01, 1'b0, 32'd0,  2'b00, 2'b01, 2'b00, 32'd0,   32'd0, 2'b00, 32'd0,  3'd0, 1'b1);
        tbl[2]  = mk(2'b00, 1'b0, 32'd0,  2'b00, 2'b00, 2'b11, 32'd100, 32'd7, 2'b00, 32'd0,  3'd0, 1'b1);
        tbl[3]  = mk(2'b00, 1'b1, 32'd14, 2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b00, 32'd0,  3'd1, 1'b1);
        tbl[4]  = mk(2'b00, 1'b0, 32'd0,  2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b01, 32'd14, 3'd0, 1'b0);
        tbl[5]  = mk(2'b00, 1'b0, 32'd0,  2'b01, 2'b00, 2'b00, 32'd100, 32'd7, 2'b01, 32'd14, 3'd0, 1'b0);
        tbl[6]  = mk(2'b00, 1'b0, 32'd0,  2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b00, 32'd0,  3'd0, 1'b1);
        tbl[7]  = mk(2'b11, 1'b0, 32'd0,  2'b00, 2'b10, 2'b00, 32'd100, 32'd7, 2'b00, 32'd0,  3'd0, 1'b1);
        tbl[8]  = mk(2'b11, 1'b0, 32'd0,  2'b00, 2'b00, 2'b11, 32'd200, 32'd9, 2'b00, 32'd0,  3'd0, 1'b1);
        tbl[9]  = mk(2'b11, 1'b0, 32'd0,  2'b00, 2'b01, 2'b00, 32'd200, 32'd9, 2'b00, 32'd0,  3'd1, 1'b1);
        tbl[10] = mk(2'b11, 1'b0, 32'd0,  2'b00, 2'b00, 2'b11, 32'd100, 32'd7, 2'b00, 32'd0,  3'd1, 1'b1);
        tbl[11] = mk(2'b00, 1'b1, 32'd22, 2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b00, 32'd0,  3'd2, 1'b1);
        tbl[12] = mk(2'b00, 1'b1, 32'd14, 2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b10, 32'd22, 3'd1, 1'b0);
        tbl[13] = mk(2'b00, 1'b1, 32'd14, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7, 2'b10, 32'd22, 3'd1, 1'b0);
        tbl[14] = mk(2'b00, 1'b1, 32'd14, 2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b00, 32'd0,  3'd1, 1'b1);
        tbl[15] = mk(2'b00, 1'b0, 32'd0,  2'b01, 2'b00, 2'b00, 32'd100, 32'd7, 2'b01, 32'd14, 3'd0, 1'b0);
        tbl[16] = mk(2'b00, 1'b0, 32'd0,  2'b00, 2'b00, 2'b00, 32'd100, 32'd7, 2'b00, 32'd0,  3'd0, 1'b1);

        rst = 1'b1;
        req_valid = '0; rsp_ready = '0;
        req_dividend = {32'd200, 32'd100};
        req_divisor  = {32'd9, 32'd7};
        dvd_tready = 1'b1; dvs_tready = 1'b1;
        dout_tvalid = 1'b0; dout_tdata = '0;
        tick;
        tick;
        rst = 1'b0;

        // single request, then both requesters contending with in-order result routing
        for (int i = 0; i < 17; i++) begin
            req_valid = tbl[i].rv; dout_tvalid = tbl[i].dv; dout_tdata = tbl[i].dd; rsp_ready = tbl[i].rspr;
            #1;
            n_vec++;
            if ({req_ready, dvd_tvalid, dvs_tvalid, dvd_tdata, dvs_tdata, rsp_valid, rsp_data, outstanding, dout_tready} !==
                {tbl[i].rr, tbl[i].tv, tbl[i].dvdd, tbl[i].dvsd, tbl[i].rspv, tbl[i].rd, tbl[i].outs, tbl[i].dtr}) begin
                n_bad++;
                $display("FAIL row %0d: got rr=%b tv=%b%b dd=%0d ds=%0d rv=%b rd=%0d out=%0d dtr=%b want rr=%b tv=%b dd=%0d ds=%0d rv=%b rd=%0d out=%0d dtr=%b",
                         i, req_ready, dvd_tvalid, dvs_tvalid, dvd_tdata, dvs_tdata, rsp_valid, rsp_data, outstanding, dout_tready,
                         tbl[i].rr, tbl[i].tv, tbl[i].dvdd, tbl[i].dvsd, tbl[i].rspv, tbl[i].rd, tbl[i].outs, tbl[i].dtr);
            end
            tick;
        end

        // divisor channel stalls three cycles while dividend completes at once
        req_valid = 2'b10; dout_tvalid = 1'b0; rsp_ready = '0; dvs_tready = 1'b0;
        #1; chk("a_grant", req_ready, 2'b10); tick;
        req_valid = 2'b00;
        #1; chk("a_tv_both", {dvd_tvalid, dvs_tvalid}, 2'b11);
        chk("a_data", {dvd_tdata, dvs_tdata}, {32'd200, 32'd9}); tick;
        #1; chk("a_dvd_drop", {dvd_tvalid, dvs_tvalid, outstanding}, {2'b01, 3'd0}); tick;
        #1; chk("a_dvs_hold3", {dvd_tvalid, dvs_tvalid, req_ready}, {2'b01, 2'b00}); tick;
        dvs_tready = 1'b1;
        #1; chk("a_dvs_hold4", {dvs_tvalid, dvs_tdata}, {1'b1, 32'd9}); tick;
        #1; chk("a_single_push", {dvs_tvalid, outstanding}, {1'b0, 3'd1});
        dout_tvalid = 1'b1; dout_tdata = 32'd22; tick;
        dout_tvalid = 1'b0; rsp_ready = 2'b10;
        #1; chk("a_rsp", {rsp_valid, rsp_data}, {2'b10, 32'd22}); tick;
        rsp_ready = '0;
        #1; chk("a_drained", {rsp_valid, outstanding}, {2'b00, 3'd0});

        // divider withholds results: only MAX_OUT requests may be in flight
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            req_valid = 2'b01;
            #1;
            if (req_ready[0]) acc++;
            tick;
        end
        #1; chk("b_accepts", acc, 4);
        chk("b_out_full", outstanding, 3'd4);
        chk("b_blocked", req_ready, 2'b00);
        dout_tvalid = 1'b1; dout_tdata = 32'd11; tick;
        dout_tvalid = 1'b0;
        #1; chk("b_out_pop", outstanding, 3'd3);
        chk("b_regrant", req_ready, 2'b01);
        chk("b_rsp", {rsp_valid, rsp_data}, {2'b01, 32'd11}); tick;
        req_valid = 2'b00; tick;
        #1; chk("b_refill", outstanding, 3'd4);

        // reset with operations in flight, then divide-by-zero counting
        rst = 1'b1; req_valid = 2'b01;
        tick; tick;
        #1; chk("rst_ready", req_ready, 2'b00);
        chk("rst_regs", {dvd_tvalid, dvs_tvalid, rsp_valid, dout_tready, outstanding, zero_div_cnt, unexp_rsp},
            {2'b00, 2'b00, 1'b0, 3'd0, 16'd0, 1'b0});
        chk("rst_tdata", {dvd_tdata, dvs_tdata}, 64'd0);
        rst = 1'b0; req_valid = 2'b11;
        #1; chk("rst_lastgrant", req_ready, 2'b01);
        req_valid = 2'b00; req_divisor = {32'd9, 32'd0};
        tick;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = acc < 2 ? 2'b01 : 2'b00;
            #1;
            if (req_ready[0]) acc++;
            tick;
        end
        #1; chk("c_zero_cnt", zero_div_cnt, 16'd2);
        chk("c_out", outstanding, 3'd2);
        chk("c_fwd_zero", dvs_tdata, 32'd0);
        rst = 1'b1; tick;
        rst = 1'b0; dout_tvalid = 1'b1; dout_tdata = 32'd99; tick;
        dout_tvalid = 1'b0;
        #1; chk("c_unexp", {unexp_rsp, rsp_valid, outstanding, zero_div_cnt}, {1'b1, 2'b00, 3'd0, 16'd0}); tick;
        #1; chk("c_unexp_sticky", {unexp_rsp, rsp_valid}, {1'b1, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
